// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl
//   Drives an external SR flip-flop to a requested state and verifies the
//   result through its Q/Qbar feedback. Each drive is a pulse on S or R,
//   then a quiet settle window, then a one-cycle check of the synchronized
//   feedback. A failed check re-drives up to MAX_RETRY times before
//   reporting an error. If the latch already holds the target when a
//   request arrives, it answers with DONE straight away and never drives
//   S or R.
//
// Parameters
//   PULSE_CYC  : S/R pulse length in cycles (1-15)
//   SETTLE_CYC : quiet cycles between pulse and check (2-15)
//   MAX_RETRY  : re-drives allowed after a failed check (0-3)
//
// Ports
//   CLK     in   rising-edge clock
//   RST_N   in   asynchronous active-low reset
//   REQ     in   request to force the latch to TGT
//   TGT     in   target latch state, valid with REQ (1 = set)
//   Q_FB    in   flip-flop Q, asynchronous to CLK
//   QBAR_FB in   flip-flop Qbar, asynchronous to CLK
//   S       out  set drive
//   R       out  reset drive
//   BUSY    out  operation in progress
//   DONE    out  one-cycle pulse, latch verified at TGT
//   ERR     out  one-cycle pulse, retries exhausted
//   RETRIES out  re-drives used by the last completed operation
module sr_drive_ctrl #(
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ,
  input  logic       TGT,
  input  logic       Q_FB,
  input  logic       QBAR_FB,
  output logic       S,
  output logic       R,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] RETRIES
);

  localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYC - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  state_t     state, state_nxt;
  logic       q_meta, q_sync, qb_meta, qb_sync;
  logic       tgt_lat, tgt_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] retry, retry_nxt;
  logic       s_nxt, r_nxt, busy_nxt, done_nxt, err_nxt;
  logic [1:0] retries_nxt;
  logic       fb_valid, fb_match, fb_match_req, accept;

  // Feedback is only trusted when Q and Qbar disagree. At acceptance the
  // target has not been latched yet, so that comparison uses TGT directly.
  // Requests are ignored while busy and in the cycle DONE/ERR is shown.
  assign fb_valid     = q_sync ^ qb_sync;
  assign fb_match     = fb_valid && (q_sync == tgt_lat);
  assign fb_match_req = fb_valid && (q_sync == TGT);
  assign accept       = REQ && !BUSY && !DONE && !ERR;

  // Two-flop synchronizers for the asynchronous flip-flop feedback.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_meta  <= 1'b0;
      q_sync  <= 1'b0;
      qb_meta <= 1'b0;
      qb_sync <= 1'b0;
    end else begin
      q_meta  <= Q_FB;
      q_sync  <= q_meta;
      qb_meta <= QBAR_FB;
      qb_sync <= qb_meta;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered outputs and datapath. Reset clears S/R at once, so an
  // operation cut short by reset never leaves a drive asserted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tgt_lat <= 1'b0;
      cnt     <= 4'd0;
      retry   <= 2'd0;
      S       <= 1'b0;
      R       <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      RETRIES <= 2'd0;
    end else begin
      tgt_lat <= tgt_nxt;
      cnt     <= cnt_nxt;
      retry   <= retry_nxt;
      S       <= s_nxt;
      R       <= r_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      ERR     <= err_nxt;
      RETRIES <= retries_nxt;
    end
  end

  // Next-state and next-output logic. S and R are only ever driven as the
  // pair (tgt, ~tgt) or both low, which rules out S and R both being high.
  // The cycle counter is loaded with length-1 on entry to DRIVE or SETTLE
  // and the phase ends on the edge where it reads zero.
  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt_lat;
    cnt_nxt     = cnt;
    retry_nxt   = retry;
    s_nxt       = 1'b0;
    r_nxt       = 1'b0;
    busy_nxt    = BUSY;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    retries_nxt = RETRIES;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_nxt   = TGT;
          retry_nxt = 2'd0;
          if (fb_match_req) begin
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
            retries_nxt = 2'd0;
          end else begin
            state_nxt = DRIVE;
            s_nxt     = TGT;
            r_nxt     = ~TGT;
            cnt_nxt   = PULSE_LOAD;
            busy_nxt  = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          s_nxt   = tgt_lat;
          r_nxt   = ~tgt_lat;
          cnt_nxt = cnt - 4'd1;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nxt = CHECK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      CHECK: begin
        if (fb_match) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          retries_nxt = retry;
        end else if (retry == RETRY_LIMIT) begin
          state_nxt   = IDLE;
          err_nxt     = 1'b1;
          busy_nxt    = 1'b0;
          retries_nxt = retry;
        end else begin
          state_nxt = DRIVE;
          retry_nxt = retry + 2'd1;
          s_nxt     = tgt_lat;
          r_nxt     = ~tgt_lat;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/sr_drive_ctrl.md
SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 2: S/R drive pulse length in cycles, legal range 1-15.
REQ-002 SHALL have parameter SETTLE_CYC, default 2: idle cycles after a pulse before feedback is checked, legal range 2-15.
REQ-003 SHALL have parameter MAX_RETRY, default 3: re-drives allowed after a failed check, legal range 0-3.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; port names CLK and RST_N.
REQ-005 CLK  input  1  rising-edge clock for all state.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 REQ  input  1  request to force the latch to TGT; sampled on the rising edge of CLK.
REQ-008 TGT  input  1  target latch state (1 = set, 0 = reset); valid with REQ.
REQ-009 Q_FB  input  1  Q of the driven SR flip-flop; asynchronous to CLK.
REQ-010 QBAR_FB  input  1  Qbar of the driven SR flip-flop; asynchronous to CLK.
REQ-011 S  output  1  set drive to the flip-flop.
REQ-012 R  output  1  reset drive to the flip-flop.
REQ-013 BUSY  output  1  high from the cycle after REQ is accepted until DONE or ERR is asserted.
REQ-014 DONE  output  1  one-cycle pulse: latch verified at TGT.
REQ-015 ERR  output  1  one-cycle pulse: retries exhausted without verification.
REQ-016 RETRIES  output  2  re-drives used by the last completed operation.

Function
REQ-017 Q_FB and QBAR_FB SHALL each pass through a two-flop synchronizer; all checks SHALL use only the synchronized values.
REQ-018 Feedback SHALL be "valid" only when synced Q != synced Qbar, and "match" only when it is valid and synced Q == latched TGT.
REQ-019 The state machine SHALL have exactly four states: IDLE, DRIVE, SETTLE, CHECK. All outputs SHALL be registered.
REQ-020 IDLE: a REQ=1 sample SHALL latch TGT, clear the retry counter, and set BUSY at the next edge.
REQ-021 IDLE: if feedback already matches on acceptance, the block SHALL stay in IDLE and pulse DONE in the next cycle, with no S/R activity; BUSY SHALL stay 0 and RETRIES SHALL load 0.
REQ-022 IDLE: otherwise the block SHALL move to DRIVE.
REQ-023 DRIVE: S=TGT and R=~TGT for exactly PULSE_CYC cycles, then the block SHALL move to SETTLE.
REQ-024 SETTLE: S=R=0 for exactly SETTLE_CYC cycles, then the block SHALL move to CHECK.
REQ-025 CHECK lasts one cycle. On match: next cycle DONE=1, BUSY=0, RETRIES=count, state IDLE.
REQ-026 CHECK on mismatch or invalid feedback with count<MAX_RETRY: the block SHALL increment count and return to DRIVE.
REQ-027 CHECK on mismatch or invalid feedback with count==MAX_RETRY: next cycle ERR=1, BUSY=0, RETRIES=count, state IDLE.
REQ-028 S and R SHALL never be 1 in the same cycle under any input sequence.
REQ-029 REQ SHALL be ignored while BUSY=1 and in the cycle DONE or ERR is high; TGT changes outside acceptance SHALL have no effect.
REQ-030 DONE and ERR SHALL be mutually exclusive; RETRIES SHALL hold between operations.
REQ-031 Latency with defaults, REQ sampled at edge 0, mismatch: S/R high in cycles 1-2, SETTLE in cycles 3-4, CHECK in cycle 5, DONE in cycle 6.

Reset
REQ-032 RST_N=0 SHALL immediately force: state IDLE; S, R, BUSY, DONE, ERR = 0; RETRIES = 0; synchronizers, counters and latched TGT cleared.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no DONE or ERR; S/R SHALL drop asynchronously.
REQ-034 After RST_N deasserts, the first REQ SHALL be accepted no earlier than the first rising edge after deassertion.

Verification
REQ-035 Latch at 0, REQ with TGT=1, defaults -> S=1 in cycles 1-2, R=0 throughout, DONE in cycle 6, RETRIES=0.
REQ-036 Latch already at 1, REQ with TGT=1 -> DONE in cycle 1, S=R=0, BUSY stays 0.
REQ-037 Feedback stuck at Q=0/Qbar=1, TGT=1, MAX_RETRY=3 -> four S pulses, ERR one cycle after the fourth CHECK, RETRIES=3, no DONE.
REQ-038 Feedback Q=Qbar=1 at the first CHECK, then correct -> exactly one retry, then DONE with RETRIES=1.
REQ-039 RST_N pulsed low during DRIVE -> S/R drop at once, no DONE or ERR, and the next REQ completes normally.
REQ-040 REQ held high throughout with random TGT, plus randomized RST_N -> S&R never both 1, and exactly one DONE or ERR per accepted REQ.
